axil_mem_model: RTL and testbench
=================================

AXIL_MEM_MODEL -- requirements
Module: axil_mem_model

Interface
REQ-001 DATA_W, 32, data width in bits; legal values 32 or 64.
REQ-002 MEM_BYTES, 131072, backing-store size in bytes; power of two.
REQ-003 RD_LAT, 1, cycles from AR handshake to RVALID; legal range 1..15.
REQ-004 WR_LAT, 1, cycles from AW+W both latched to BVALID; legal range 1..15.
REQ-005 STALL_EN, 0, 1 = pseudo-random ready/latency stalls enabled.
REQ-006 CONSOLE_ADDR, 32'h1000_0000, console byte register address.
REQ-007 PASS_ADDR, 32'h2000_0000, pass-flag register address.
REQ-008 PASS_MAGIC, 123456789, write value that sets tests_passed.
REQ-009 clk  in  1  clock; all logic on rising edge.
REQ-010 resetn  in  1  reset; asynchronous, active-high.
REQ-011 s_awvalid/s_awready  in/out  1  write-address handshake; s_awaddr  in  32.
REQ-012 s_wvalid/s_wready  in/out  1  write-data handshake; s_wdata  in  DATA_W; s_wstrb  in  DATA_W/8.
REQ-013 s_bvalid/s_bready  out/in  1  write response; s_bresp  out  2.
REQ-014 s_arvalid/s_arready  in/out  1  read-address handshake; s_araddr  in  32.
REQ-015 s_rvalid/s_rready  out/in  1  read response; s_rdata  out  DATA_W; s_rresp  out  2.
REQ-016 console_valid  out  1  one-cycle strobe; console_data  out  8  console byte.
REQ-017 tests_passed  out  1  sticky pass flag; err_oob  out  1  sticky out-of-bounds flag.

Function
REQ-018 Word index = addr[log2(MEM_BYTES)-1 : log2(DATA_W/8)]; low address bits ignored.
REQ-019 Read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE; s_arready high only in R_IDLE (and not stalled).
REQ-020 AR handshake at edge N latches address; s_rvalid rises after edge N+RD_LAT; memory sampled on entry to R_RESP.
REQ-021 s_rvalid, s_rdata, s_rresp held stable until s_rready; R handshake returns FSM to R_IDLE; s_arready low in handshake cycle.
REQ-022 Write FSM W_IDLE (collect) -> W_WAIT -> W_RESP; AW and W accepted independently, either order or same cycle.
REQ-023 s_awready low once AW latched, s_wready low once W latched, both until B handshake completes.
REQ-024 WR_LAT cycles after both latched: commit byte lanes per s_wstrb, enter W_RESP with s_bvalid=1, held until s_bready.
REQ-025 Write to CONSOLE_ADDR with wstrb[0]: console_valid high exactly one cycle at commit, console_data = wdata[7:0]; memory unchanged.
REQ-026 Write to PASS_ADDR with wdata[31:0]==PASS_MAGIC sets tests_passed; other values no effect; cleared only by reset.
REQ-027 Read of PASS_ADDR returns zero-extended tests_passed; read of CONSOLE_ADDR returns 0; both OKAY.
REQ-028 Other address >= MEM_BYTES: read returns 0, write not committed, resp SLVERR (2'b10), err_oob set; else resp OKAY (2'b00).
REQ-029 Read commit and write commit to same word in same cycle: read returns pre-write data.
REQ-030 STALL_EN=1: xorshift64 advances each cycle; bits 0/1/2 block arready/awready/wready; bits 3/4 freeze read/write latency counters.
REQ-031 Stall never deasserts an already-asserted valid or ready mid-handshake.

Reset
REQ-032 While resetn=1 (asynchronous): all valid/ready 0, s_rdata 0, resps 0, console_valid 0, tests_passed 0, err_oob 0, FSMs idle, counters 0.
REQ-033 LFSR reset seed 64'd88172645463325252; memory array not reset (preloaded by bench via $readmemh on instance array mem).
REQ-034 Reset asserted mid-transaction abandons it; uncommitted write never reaches memory.

Structure
REQ-035 Package axil_mem_pkg holds: resp codes OKAY/SLVERR, read/write FSM state enums, default CONSOLE/PASS addresses, PASS_MAGIC, LFSR seed.
REQ-036 One sub-module axil_mem_xorshift64 (64-bit xorshift, shifts 13/7/17, enable input); memory inferred inside top.

Verification
REQ-037 RD_LAT=3, STALL_EN=0, preload mem[4]=32'hDEADBEEF; AR 0x10 at edge N -> rvalid after edge N+3, rdata DEADBEEF, OKAY.
REQ-038 W (0x11223344, strb 4'b0101) one cycle before AW 0x20 -> bvalid OKAY; readback of 0x20 = old[31:24],0x22,old[15:8],0x44.
REQ-039 Write 0x41 to CONSOLE_ADDR -> single-cycle console_valid with console_data=0x41; write 123456789 to PASS_ADDR -> tests_passed=1 sticky.
REQ-040 Read 0x0004_0000 and write 0x0004_0000 (MEM_BYTES 131072) -> rdata 0, both resps SLVERR, err_oob=1, memory unchanged.
REQ-041 STALL_EN=1, s_rready/s_bready randomly toggled, 1000 random writes then reads -> all data matches scoreboard, valids never drop before handshake.
REQ-042 Reset asserted between AW/W latch and bvalid -> after release, target word unchanged, all outputs at reset values.

Source files
------------

// File: rtl/axil_mem_pkg.sv
// Shared types and constants for the AXI-Lite memory model: response codes,
// FSM state encodings, default register addresses and the address decoder.
package axil_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    REG_MEM,
    REG_CONSOLE,
    REG_PASS,
    REG_OOB
  } region_e;

  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;
  localparam logic [63:0] LFSR_SEED        = 64'd88172645463325252;

  // Register addresses take priority over the out-of-range check.
  function automatic region_e decode(input logic [31:0] addr,
                                     input logic [31:0] console_addr,
                                     input logic [31:0] pass_addr,
                                     input logic [31:0] mem_bytes);
    if (addr == console_addr)   return REG_CONSOLE;
    else if (addr == pass_addr) return REG_PASS;
    else if (addr >= mem_bytes) return REG_OOB;
    else                        return REG_MEM;
  endfunction

endpackage

// File: rtl/axil_mem_if.sv
// AXI-Lite slave bus bundle for the memory model.
interface axil_mem_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_awaddr;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [DATA_W-1:0]     s_wdata;
  logic [DATA_W/8-1:0]   s_wstrb;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [1:0]            s_bresp;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_araddr;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [DATA_W-1:0]     s_rdata;
  logic [1:0]            s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp
  );
endinterface

// File: rtl/axil_mem_xorshift64.sv
// 64-bit xorshift (13/7/17) pseudo-random source; low bits drive stall decisions.
module axil_mem_xorshift64
  import axil_mem_pkg::*;
#(
  parameter int unsigned OUT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [OUT_W-1:0] rnd
);
  logic [63:0] state;
  logic [63:0] nxt;

  always_comb begin
    nxt = state ^ (state << 13);
    nxt = nxt ^ (nxt >> 7);
    nxt = nxt ^ (nxt << 17);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)  state <= LFSR_SEED;
    else if (en) state <= nxt;
  end

  assign rnd = state[OUT_W-1:0];
endmodule

// File: rtl/axil_mem_model.sv
// AXI-Lite memory model with programmable latency, optional random stalls,
// a console byte register and a sticky pass flag.
module axil_mem_model
  import axil_mem_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_BYTES    = 131072,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned WR_LAT       = 1,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC
) (
  input  logic        clk,
  input  logic        resetn,
  axil_mem_if.slave   s,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        tests_passed,
  output logic        err_oob
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned MSB    = $clog2(MEM_BYTES) - 1;
  localparam int unsigned WORDS  = MEM_BYTES / STRB_W;

  logic [DATA_W-1:0] mem [WORDS];

  logic [4:0]  rnd;
  logic [4:0]  stall;

  axil_mem_xorshift64 #(.OUT_W(5)) u_rng (
    .clk    (clk),
    .resetn (resetn),
    .en     (STALL_EN),
    .rnd    (rnd)
  );

  // bits: 0 arready, 1 awready, 2 wready, 3 read latency, 4 write latency
  assign stall = STALL_EN ? rnd : '0;

  rd_state_e         rstate;
  logic [31:0]       rd_addr;
  logic [3:0]        rd_cnt;
  logic              rd_fire;
  region_e           rd_region;
  logic [MSB-LSB:0]  rd_idx;

  wr_state_e         wstate;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              aw_got;
  logic              w_got;
  logic              aw_hs;
  logic              w_hs;
  logic [3:0]        wr_cnt;
  logic              wr_fire;
  region_e           wr_region;
  logic [MSB-LSB:0]  wr_idx;
  logic              mem_we;

  assign rd_region = decode(rd_addr, CONSOLE_ADDR, PASS_ADDR, 32'(MEM_BYTES));
  assign wr_region = decode(wr_addr, CONSOLE_ADDR, PASS_ADDR, 32'(MEM_BYTES));
  assign rd_idx    = rd_addr[MSB:LSB];
  assign wr_idx    = wr_addr[MSB:LSB];
  assign rd_fire   = (rstate == R_WAIT) && !stall[3] && (rd_cnt == '0);
  assign wr_fire   = (wstate == W_WAIT) && !stall[4] && (wr_cnt == '0);
  assign mem_we    = wr_fire && (wr_region == REG_MEM);
  assign aw_hs     = s.s_awvalid && s.s_awready;
  assign w_hs      = s.s_wvalid && s.s_wready;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rstate      <= R_IDLE;
      rd_addr     <= '0;
      rd_cnt      <= '0;
      s.s_arready <= 1'b0;
      s.s_rvalid  <= 1'b0;
      s.s_rdata   <= '0;
      s.s_rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s.s_arvalid && s.s_arready) begin
            rd_addr     <= s.s_araddr;
            rd_cnt      <= 4'(RD_LAT - 1);
            s.s_arready <= 1'b0;
            rstate      <= R_WAIT;
          end else begin
            s.s_arready <= !stall[0];
          end
        end
        R_WAIT: begin
          if (!stall[3]) begin
            if (rd_cnt == '0) begin
              rstate     <= R_RESP;
              s.s_rvalid <= 1'b1;
              s.s_rresp  <= RESP_OKAY;
              case (rd_region)
                REG_MEM:  s.s_rdata <= mem[rd_idx];
                REG_PASS: s.s_rdata <= DATA_W'(tests_passed);
                REG_OOB: begin
                  s.s_rdata <= '0;
                  s.s_rresp <= RESP_SLVERR;
                end
                default:  s.s_rdata <= '0;
              endcase
            end else begin
              rd_cnt <= rd_cnt - 4'd1;
            end
          end
        end
        R_RESP: begin
          if (s.s_rready) begin
            s.s_rvalid  <= 1'b0;
            s.s_arready <= !stall[0];
            rstate      <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // AW and W are collected independently; the FSM leaves W_IDLE on the edge
  // where the second of the two is latched.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wstate        <= W_IDLE;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      wr_cnt        <= '0;
      s.s_awready   <= 1'b0;
      s.s_wready    <= 1'b0;
      s.s_bvalid    <= 1'b0;
      s.s_bresp     <= RESP_OKAY;
      console_valid <= 1'b0;
      console_data  <= '0;
      tests_passed  <= 1'b0;
    end else begin
      console_valid <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr     <= s.s_awaddr;
            aw_got      <= 1'b1;
            s.s_awready <= 1'b0;
          end else if (!aw_got) begin
            s.s_awready <= !stall[1];
          end
          if (w_hs) begin
            wr_data    <= s.s_wdata;
            wr_strb    <= s.s_wstrb;
            w_got      <= 1'b1;
            s.s_wready <= 1'b0;
          end else if (!w_got) begin
            s.s_wready <= !stall[2];
          end
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            wr_cnt <= 4'(WR_LAT - 1);
            wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (!stall[4]) begin
            if (wr_cnt == '0) begin
              wstate     <= W_RESP;
              s.s_bvalid <= 1'b1;
              s.s_bresp  <= (wr_region == REG_OOB) ? RESP_SLVERR : RESP_OKAY;
              if (wr_region == REG_CONSOLE && wr_strb[0]) begin
                console_valid <= 1'b1;
                console_data  <= wr_data[7:0];
              end
              if (wr_region == REG_PASS && wr_data[31:0] == PASS_MAGIC)
                tests_passed <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt - 4'd1;
            end
          end
        end
        W_RESP: begin
          if (s.s_bready) begin
            s.s_bvalid  <= 1'b0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            s.s_awready <= !stall[1];
            s.s_wready  <= !stall[2];
            wstate      <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      err_oob <= 1'b0;
    else if ((rd_fire && rd_region == REG_OOB) || (wr_fire && wr_region == REG_OOB))
      err_oob <= 1'b1;
  end

  // Unreset storage; the enable only exists in W_WAIT so reset cancels it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_mem_model.sv
// Bench for axil_mem_model: a fixed-latency instance for directed checks and a
// stalling instance for a randomized run against a byte-array reference model.
module tb_axil_mem_model;
  localparam int unsigned MEMB = 131072;
  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] PASS = 32'h2000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic sel = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int cons_cnt = 0;
  logic [7:0] cons_last = '0;

  always #5 clk = ~clk;

  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;

  axil_mem_if #(.DATA_W(32)) bus0 ();
  axil_mem_if #(.DATA_W(32)) bus1 ();

  logic cv0, cv1, tp0, tp1, eo0, eo1;
  logic [7:0] cd0, cd1;

  assign bus0.s_awvalid = awvalid & ~sel;
  assign bus1.s_awvalid = awvalid & sel;
  assign bus0.s_wvalid  = wvalid & ~sel;
  assign bus1.s_wvalid  = wvalid & sel;
  assign bus0.s_arvalid = arvalid & ~sel;
  assign bus1.s_arvalid = arvalid & sel;
  assign bus0.s_bready  = bready & ~sel;
  assign bus1.s_bready  = bready & sel;
  assign bus0.s_rready  = rready & ~sel;
  assign bus1.s_rready  = rready & sel;
  assign bus0.s_awaddr  = awaddr;
  assign bus1.s_awaddr  = awaddr;
  assign bus0.s_araddr  = araddr;
  assign bus1.s_araddr  = araddr;
  assign bus0.s_wdata   = wdata;
  assign bus1.s_wdata   = wdata;
  assign bus0.s_wstrb   = wstrb;
  assign bus1.s_wstrb   = wstrb;

  logic awready, wready, arready, bvalid, rvalid, tp, eo;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  assign awready = sel ? bus1.s_awready : bus0.s_awready;
  assign wready  = sel ? bus1.s_wready  : bus0.s_wready;
  assign arready = sel ? bus1.s_arready : bus0.s_arready;
  assign bvalid  = sel ? bus1.s_bvalid  : bus0.s_bvalid;
  assign rvalid  = sel ? bus1.s_rvalid  : bus0.s_rvalid;
  assign bresp   = sel ? bus1.s_bresp   : bus0.s_bresp;
  assign rresp   = sel ? bus1.s_rresp   : bus0.s_rresp;
  assign rdata   = sel ? bus1.s_rdata   : bus0.s_rdata;
  assign tp      = sel ? tp1 : tp0;
  assign eo      = sel ? eo1 : eo0;

  axil_mem_model #(.DATA_W(32), .MEM_BYTES(MEMB), .RD_LAT(3), .WR_LAT(2), .STALL_EN(1'b0)) dut (
    .clk(clk), .resetn(resetn), .s(bus0),
    .console_valid(cv0), .console_data(cd0), .tests_passed(tp0), .err_oob(eo0)
  );

  axil_mem_model #(.DATA_W(32), .MEM_BYTES(MEMB), .RD_LAT(2), .WR_LAT(3), .STALL_EN(1'b1)) dut_s (
    .clk(clk), .resetn(resetn), .s(bus1),
    .console_valid(cv1), .console_data(cd1), .tests_passed(tp1), .err_oob(eo1)
  );

  always @(negedge clk) begin
    if (sel ? cv1 : cv0) begin
      cons_cnt  = cons_cnt + 1;
      cons_last = sel ? cd1 : cd0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int aw_dly, input int w_dly, input bit rnd_b,
                          output logic [1:0] resp, output int lat, output bit hold_ok);
    bit aw_p = 1, w_p = 1, ok = 1, pend = 0, arc, wrc, bvc, brc;
    logic [1:0] prev = '0;
    int t = 0;
    awaddr = a; wdata = d; wstrb = st; hold_ok = 1; resp = 2'bxx; lat = 0;
    while (aw_p || w_p) begin
      awvalid = aw_p && (t >= aw_dly);
      wvalid  = w_p && (t >= w_dly);
      arc = awready; wrc = wready;
      @(posedge clk); #1; t++;
      if (awvalid && arc) aw_p = 0;
      if (wvalid && wrc)  w_p = 0;
      if ((!aw_p && awready) || (!w_p && wready)) hold_ok = 0;
      if (t > 200) begin ok = 0; break; end
    end
    awvalid = 0; wvalid = 0;
    while (ok && !bvalid) begin
      @(posedge clk); #1; lat++;
      if (awready || wready) hold_ok = 0;
      if (lat > 200) ok = 0;
    end
    t = 0;
    while (ok) begin
      bready = rnd_b ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend) begin
        compared++;
        if (!bvalid || bresp !== prev) begin
          mismatched++;
          $display("FAIL b_stable: bvalid=%b bresp=%b required 1/%b", bvalid, bresp, prev);
        end
      end
      bvc = bvalid; brc = bready; prev = bresp; pend = bvc && !brc; resp = bresp;
      if (awready || wready) hold_ok = 0;
      @(posedge clk); #1; t++;
      if (bvc && brc) break;
      if (t > 200) ok = 0;
    end
    bready = 0;
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL write_timeout: addr=%h no completion within budget", a);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input bit rnd_r, output logic [31:0] d,
                         output logic [1:0] resp, output int lat, output bit ar_low);
    bit ok = 1, pend = 0, c, rvc, rrc;
    logic [33:0] prev = '0;
    int t = 0;
    araddr = a; arvalid = 1; d = 'x; resp = 2'bxx; lat = 0; ar_low = 1;
    while (1) begin
      c = arready;
      @(posedge clk); #1; t++;
      if (c) break;
      if (t > 200) begin ok = 0; break; end
    end
    arvalid = 0;
    while (ok && !rvalid) begin
      @(posedge clk); #1; lat++;
      if (lat > 200) ok = 0;
    end
    t = 0;
    while (ok) begin
      rready = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend) begin
        compared++;
        if (!rvalid || {rresp, rdata} !== prev) begin
          mismatched++;
          $display("FAIL r_stable: rvalid=%b resp/data=%h required 1/%h", rvalid, {rresp, rdata}, prev);
        end
      end
      rvc = rvalid; rrc = rready; prev = {rresp, rdata}; pend = rvc && !rrc;
      d = rdata; resp = rresp;
      if (arready) ar_low = 0;
      @(posedge clk); #1; t++;
      if (rvc && rrc) break;
      if (t > 200) ok = 0;
    end
    rready = 0;
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL read_timeout: addr=%h no completion within budget", a);
    end
  endtask

  task automatic test_reset();
    logic [51:0] v0, v1;
    resetn = 1;
    cyc(3);
    v0 = {bus0.s_awready, bus0.s_wready, bus0.s_arready, bus0.s_bvalid, bus0.s_rvalid,
          bus0.s_rdata, bus0.s_bresp, bus0.s_rresp, cv0, tp0, eo0, cd0};
    v1 = {bus1.s_awready, bus1.s_wready, bus1.s_arready, bus1.s_bvalid, bus1.s_rvalid,
          bus1.s_rdata, bus1.s_bresp, bus1.s_rresp, cv1, tp1, eo1, cd1};
    compared++;
    if (v0 !== '0) begin mismatched++; $display("FAIL reset_dut: outputs=%h required 0", v0); end
    compared++;
    if (v1 !== '0) begin mismatched++; $display("FAIL reset_dut_s: outputs=%h required 0", v1); end
    resetn = 0;
    cyc(2);
    compared++;
    if ({awready, wready, arready} !== 3'b111) begin
      mismatched++; $display("FAIL ready_after_reset: got %b required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] d; logic [1:0] r; int lat; bit h;
    sel = 0;
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r, lat, h);
    compared++;
    if (r !== 2'b00 || lat != 2) begin
      mismatched++; $display("FAIL wr_latency: resp=%b lat=%0d required 00/2", r, lat);
    end
    do_read(32'h10, 0, d, r, lat, h);
    compared++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat != 3 || !h) begin
      mismatched++;
      $display("FAIL rd_latency: data=%h resp=%b lat=%0d arlow=%b required deadbeef/00/3/1", d, r, lat, h);
    end
    do_read(32'h13, 0, d, r, lat, h);
    compared++;
    if (d !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL rd_lowbits: got %h required deadbeef", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d, old, nd, exp; logic [3:0] st; logic [1:0] r; int lat; bit h;
    sel = 0;
    do_write(32'h20, 32'hA1B2_C3D4, 4'hF, 0, 0, 0, r, lat, h);
    do_write(32'h20, 32'h1122_3344, 4'b0101, 1, 0, 0, r, lat, h);
    compared++;
    if (r !== 2'b00 || !h) begin mismatched++; $display("FAIL strobe_resp: resp=%b hold=%b required 00/1", r, h); end
    do_read(32'h20, 0, d, r, lat, h);
    compared++;
    if (d !== 32'hA122_C344) begin mismatched++; $display("FAIL strobe_data: got %h required a122c344", d); end
    old = 32'hA122_C344;
    for (int i = 0; i < 4; i++) begin
      nd = $urandom; st = 4'($urandom_range(0, 15));
      do_write(32'h20, nd, st, $urandom_range(0, 2), $urandom_range(0, 2), 0, r, lat, h);
      for (int b = 0; b < 4; b++) exp[b*8 +: 8] = st[b] ? nd[b*8 +: 8] : old[b*8 +: 8];
      do_read(32'h20, 0, d, r, lat, h);
      compared++;
      if (d !== exp || !h) begin
        mismatched++; $display("FAIL strobe_rand: got %h hold=%b required %h/1 (strb %b)", d, h, exp, st);
      end
      old = exp;
    end
  endtask

  task automatic test_console_pass();
    logic [31:0] d; logic [1:0] r; int lat, c0; bit h;
    sel = 0;
    do_write(32'h0, 32'h5A5A_1234, 4'hF, 0, 0, 0, r, lat, h);
    c0 = cons_cnt;
    do_write(CON, 32'h0000_0041, 4'b0001, 0, 0, 0, r, lat, h);
    cyc(2);
    compared++;
    if (cons_cnt - c0 != 1 || cons_last !== 8'h41 || r !== 2'b00) begin
      mismatched++;
      $display("FAIL console: pulses=%0d data=%h resp=%b required 1/41/00", cons_cnt - c0, cons_last, r);
    end
    c0 = cons_cnt;
    do_write(CON, 32'h0000_5555, 4'b0010, 0, 0, 0, r, lat, h);
    cyc(2);
    compared++;
    if (cons_cnt != c0) begin mismatched++; $display("FAIL console_nostrb: pulses=%0d required 0", cons_cnt - c0); end
    do_write(PASS, 32'h0001_2345, 4'hF, 0, 0, 0, r, lat, h);
    compared++;
    if (tp !== 1'b0) begin mismatched++; $display("FAIL pass_wrong: tests_passed=%b required 0", tp); end
    do_write(PASS, 32'd123456789, 4'hF, 0, 0, 0, r, lat, h);
    compared++;
    if (tp !== 1'b1) begin mismatched++; $display("FAIL pass_magic: tests_passed=%b required 1", tp); end
    do_write(PASS, 32'h0, 4'hF, 0, 0, 0, r, lat, h);
    do_read(PASS, 0, d, r, lat, h);
    compared++;
    if (tp !== 1'b1 || d !== 32'h1 || r !== 2'b00) begin
      mismatched++; $display("FAIL pass_sticky: flag=%b rd=%h resp=%b required 1/1/00", tp, d, r);
    end
    do_read(CON, 0, d, r, lat, h);
    compared++;
    if (d !== 32'h0 || r !== 2'b00) begin mismatched++; $display("FAIL console_read: got %h/%b required 0/00", d, r); end
    do_read(32'h0, 0, d, r, lat, h);
    compared++;
    if (d !== 32'h5A5A_1234 || eo !== 1'b0) begin
      mismatched++; $display("FAIL reg_no_alias: word0=%h err=%b required 5a5a1234/0", d, eo);
    end
  endtask

  task automatic test_oob();
    logic [31:0] d; logic [1:0] r; int lat; bit h;
    sel = 0;
    do_read(32'h0004_0000, 0, d, r, lat, h);
    compared++;
    if (d !== 32'h0 || r !== 2'b10 || eo !== 1'b1) begin
      mismatched++; $display("FAIL oob_read: data=%h resp=%b err=%b required 0/10/1", d, r, eo);
    end
    do_write(32'h0004_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, lat, h);
    compared++;
    if (r !== 2'b10) begin mismatched++; $display("FAIL oob_write: resp=%b required 10", r); end
    do_read(32'h0, 0, d, r, lat, h);
    compared++;
    if (d !== 32'h5A5A_1234 || eo !== 1'b1) begin
      mismatched++; $display("FAIL oob_unchanged: word0=%h err=%b required 5a5a1234/1", d, eo);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d; logic [1:0] r; int lat; bit h;
    sel = 0;
    do_write(32'h30, 32'h0102_0304, 4'hF, 0, 0, 0, r, lat, h);
    cyc(2);
    araddr = 32'h30; arvalid = 1;
    cyc(1);
    arvalid = 0;
    awaddr = 32'h30; wdata = 32'hA0B0_C0D0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cyc(1);
    awvalid = 0; wvalid = 0; rready = 1; bready = 1;
    cyc(2);
    compared++;
    if (rvalid !== 1'b1 || bvalid !== 1'b1 || rdata !== 32'h0102_0304) begin
      mismatched++;
      $display("FAIL same_cycle: rvalid=%b bvalid=%b rdata=%h required 1/1/01020304", rvalid, bvalid, rdata);
    end
    cyc(1);
    rready = 0; bready = 0;
    cyc(1);
    do_read(32'h30, 0, d, r, lat, h);
    compared++;
    if (d !== 32'hA0B0_C0D0) begin mismatched++; $display("FAIL same_cycle_after: got %h required a0b0c0d0", d); end
  endtask

  task automatic test_random_stall();
    logic [7:0] mb [256];
    bit mv [256];
    logic [31:0] a, d, exp, mask; logic [3:0] st; logic [1:0] r; int lat; bit h;
    int idx;
    sel = 1;
    for (int i = 0; i < 256; i++) mv[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      idx = $urandom_range(0, 63);
      a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      d = $urandom; st = 4'($urandom_range(1, 15));
      do_write(a, d, st, $urandom_range(0, 2), $urandom_range(0, 2), 1, r, lat, h);
      for (int b = 0; b < 4; b++)
        if (st[b]) begin mb[idx*4 + b] = d[b*8 +: 8]; mv[idx*4 + b] = 1; end
      compared++;
      if (r !== 2'b00 || !h) begin
        mismatched++; $display("FAIL rand_wr: addr=%h resp=%b hold=%b required 00/1", a, r, h);
      end
    end
    for (int w = 0; w < 64; w++) begin
      do_read(32'(w) << 2, 1, d, r, lat, h);
      for (int b = 0; b < 4; b++) begin
        exp[b*8 +: 8]  = mv[w*4 + b] ? mb[w*4 + b] : 8'h00;
        mask[b*8 +: 8] = mv[w*4 + b] ? 8'hFF : 8'h00;
      end
      compared++;
      if ((d & mask) !== (exp & mask) || r !== 2'b00) begin
        mismatched++; $display("FAIL rand_rd: word=%0d got %h/%b required %h/00 (mask %h)", w, d, r, exp, mask);
      end
    end
    sel = 0;
  endtask

  task automatic test_reset_midwrite();
    logic [31:0] d; logic [1:0] r; int lat; bit h;
    logic [50:0] v;
    sel = 0;
    do_write(32'h40, 32'h1357_2468, 4'hF, 0, 0, 0, r, lat, h);
    cyc(2);
    awaddr = 32'h40; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cyc(1);
    awvalid = 0; wvalid = 0;
    resetn = 1;
    #1;
    v = {bus0.s_awready, bus0.s_wready, bus0.s_arready, bus0.s_bvalid, bus0.s_rvalid,
         bus0.s_rdata, bus0.s_bresp, bus0.s_rresp, cv0, tp0, eo0};
    compared++;
    if (v !== '0) begin mismatched++; $display("FAIL async_reset: outputs=%h required 0", v); end
    cyc(3);
    resetn = 0;
    v = {bus0.s_awready, bus0.s_wready, bus0.s_arready, bus0.s_bvalid, bus0.s_rvalid,
         bus0.s_rdata, bus0.s_bresp, bus0.s_rresp, cv0, tp0, eo0};
    compared++;
    if (v !== '0) begin mismatched++; $display("FAIL release_state: outputs=%h required 0", v); end
    cyc(2);
    do_read(32'h40, 0, d, r, lat, h);
    compared++;
    if (d !== 32'h1357_2468 || tp !== 1'b0 || eo !== 1'b0) begin
      mismatched++; $display("FAIL abandoned_write: word=%h tp=%b err=%b required 13572468/0/0", d, tp, eo);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_strobe();
    test_console_pass();
    test_oob();
    test_same_cycle();
    test_random_stall();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
